key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 128 ++++++++++++
 tb/tb_key_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// rtl/key_loader.sv - DES key byte loader: collects 8 key bytes MSB first and applies PC-1.
// Optional feature macro: PARITY_CHK_EN enables odd-parity checking of every accepted byte.
module key_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        iLd,
    input  logic [7:0]  byteIn,
    input  logic        byteVld,
    output logic        byteRdy,
    output logic        fPd,
    output logic [55:0] outKey,
    output logic        errPar
);

`ifdef PARITY_CHK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    // PC-1 selection in FIPS 46-3 bit numbering (1 = MSB of the 64-bit key)
    localparam logic [6:0] PC1 [0:55] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    typedef enum logic [2:0] {IDLE, LOAD, PERM, HOLD, ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] key_q, key_d;
    logic [55:0] out_key_q, out_key_d;
    logic        fpd_q, fpd_d;
    logic        err_par_q, err_par_d;
    logic        par_bad_q, par_bad_d;
    logic        byte_bad;

    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        logic [5:0]  pos;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            pos = 6'(7'd64 - PC1[i]);
            r[55-i] = k[pos];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            key_q     <= 64'h0;
            out_key_q <= 56'h0;
            fpd_q     <= 1'b0;
            err_par_q <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            out_key_q <= out_key_d;
            fpd_q     <= fpd_d;
            err_par_q <= err_par_d;
            par_bad_q <= par_bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        out_key_d = out_key_q;
        fpd_d     = fpd_q;
        err_par_d = err_par_q;
        par_bad_d = par_bad_q;
        byte_bad  = PAR_EN & ~(^byteIn);

        // A load pulse restarts from any state and wins over a byte offered in the same cycle
        if (iLd) begin
            state_d   = LOAD;
            cnt_d     = 3'd0;
            key_d     = 64'h0;
            fpd_d     = 1'b0;
            err_par_d = 1'b0;
            par_bad_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: begin
                    if (byteVld) begin
                        key_d[{~cnt_q, 3'b000} +: 8] = byteIn;
                        cnt_d     = cnt_q + 3'd1;
                        par_bad_d = par_bad_q | byte_bad;
                        if (cnt_q == 3'd7) begin
                            if (par_bad_q | byte_bad) begin
                                state_d   = ERR;
                                err_par_d = 1'b1;
                            end else begin
                                state_d = PERM;
                            end
                        end
                    end
                end
                PERM: begin
                    out_key_d = pc1_perm(key_q);
                    fpd_d     = 1'b1;
                    state_d   = HOLD;
                end
                HOLD: ;
                ERR:  ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign byteRdy = (state_q == LOAD);
    assign fPd     = fpd_q;
    assign outKey  = out_key_q;
    assign errPar  = PAR_EN & err_par_q;

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - self-checking bench for key_loader against a PC-1 reference model.
module tb_key_loader;

    logic        clk;
    logic        rst;
    logic        iLd;
    logic [7:0]  byteIn;
    logic        byteVld;
    logic        byteRdy;
    logic        fPd;
    logic [55:0] outKey;
    logic        errPar;

    int checks = 0;
    int errors = 0;
    logic [55:0] last_exp;

    key_loader dut (
        .clk     (clk),
        .rst     (rst),
        .iLd     (iLd),
        .byteIn  (byteIn),
        .byteVld (byteVld),
        .byteRdy (byteRdy),
        .fPd     (fPd),
        .outKey  (outKey),
        .errPar  (errPar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };

    // Reference: pick key bit n (1 = MSB) for each PC-1 entry, shifting results in MSB first
    function automatic logic [55:0] ref_pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r = {r[54:0], 1'(k >> (64 - PC1_T[i]))};
        return r;
    endfunction

    function automatic logic [7:0] odd_fix(input logic [7:0] b);
        logic [7:0] o;
        o = b;
        o[0] = ~^b[7:1];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Streams 8 bytes (optional stall of gap_len cycles before byte gap_pos) and waits for fPd
    task automatic send_bytes(input logic [63:0] key, input int gap_pos, input int gap_len,
                              output int lat);
        lat = 0;
        for (int b = 0; b < 8; b++) begin
            if (b == gap_pos) begin
                byteVld = 1'b0;
                repeat (gap_len) begin
                    step();
                    lat++;
                end
            end
            byteVld = 1'b1;
            byteIn  = key[63-8*b -: 8];
            if (b == 0) check("byte_rdy_in_load", 64'(byteRdy), 64'd1);
            step();
            lat++;
        end
        byteVld = 1'b0;
        while (!fPd && lat < 64) begin
            step();
            lat++;
        end
        if (!fPd) check("fpd_timeout", 64'(fPd), 64'd1);
    endtask

    task automatic load_key(input logic [63:0] key, input int gap_pos, input int gap_len,
                            output int lat);
        iLd = 1'b1;
        step();
        iLd = 1'b0;
        check("outkey_held_during_load", 64'(outKey), 64'(last_exp));
        send_bytes(key, gap_pos, gap_len, lat);
    endtask

    typedef struct {
        logic [63:0] key;
        int          gap_pos;
        int          gap_len;
        logic [55:0] exp_key;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int   lat;
        vec_t v;
        logic [63:0] rk;

        rst = 1'b1; iLd = 1'b0; byteIn = 8'h00; byteVld = 1'b0;
        last_exp = 56'h0;

        vecs.push_back('{64'h133457799BBCDFF1, -1, 0, 56'hF0CCAAF556678F});
        vecs.push_back('{64'h0101010101010101, -1, 0, 56'h00000000000000});
        vecs.push_back('{64'hFEFEFEFEFEFEFEFE, -1, 0, 56'hFFFFFFFFFFFFFF});
        vecs.push_back('{64'h133457799BBCDFF1, 4, 3, 56'hF0CCAAF556678F});
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 8; b++)
                rk[63-8*b -: 8] = odd_fix(8'($urandom_range(0, 255)));
            v.key     = rk;
            v.gap_pos = int'($urandom_range(0, 7));
            v.gap_len = int'($urandom_range(0, 3));
            v.exp_key = ref_pc1(rk);
            vecs.push_back(v);
        end

        repeat (2) step();
        check("reset_byte_rdy", 64'(byteRdy), 64'd0);
        check("reset_fpd", 64'(fPd), 64'd0);
        check("reset_err_par", 64'(errPar), 64'd0);
        check("reset_out_key", 64'(outKey), 64'd0);
        rst = 1'b0;
        step();
        check("idle_byte_rdy", 64'(byteRdy), 64'd0);

        foreach (vecs[i]) begin
            load_key(vecs[i].key, vecs[i].gap_pos, vecs[i].gap_len, lat);
            check($sformatf("vec%0d_out_key", i), 64'(outKey), 64'(vecs[i].exp_key));
            check($sformatf("vec%0d_latency", i), 64'(lat),
                  64'(9 + ((vecs[i].gap_pos >= 0) ? vecs[i].gap_len : 0)));
            check($sformatf("vec%0d_err_par", i), 64'(errPar), 64'd0);
            check($sformatf("vec%0d_hold_rdy", i), 64'(byteRdy), 64'd0);
            last_exp = vecs[i].exp_key;
        end

        // Abort after 5 bytes; the restart cycle also offers a byte that must be dropped
        iLd = 1'b1;
        step();
        iLd = 1'b0;
        for (int b = 0; b < 5; b++) begin
            byteVld = 1'b1;
            byteIn  = 8'hA7;
            step();
        end
        iLd = 1'b1; byteVld = 1'b1; byteIn = 8'hFF;
        step();
        iLd = 1'b0; byteVld = 1'b0;
        check("abort_byte_rdy", 64'(byteRdy), 64'd1);
        check("abort_fpd", 64'(fPd), 64'd0);
        send_bytes(64'h0101010101010101, -1, 0, lat);
        check("abort_out_key", 64'(outKey), 64'h0);
        check("abort_latency", 64'(lat), 64'd9);
        last_exp = 56'h0;

        // iLd in HOLD drops fPd but keeps outKey
        iLd = 1'b1;
        step();
        iLd = 1'b0;
        check("hold_reload_fpd", 64'(fPd), 64'd0);
        check("hold_reload_rdy", 64'(byteRdy), 64'd1);

        // Reset mid-LOAD discards the partial key
        for (int b = 0; b < 3; b++) begin
            byteVld = 1'b1;
            byteIn  = 8'h5B;
            step();
        end
        byteVld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midload_rst_rdy", 64'(byteRdy), 64'd0);
        load_key(64'h133457799BBCDFF1, -1, 0, lat);
        check("after_rst_out_key", 64'(outKey), 64'hF0CCAAF556678F);

        // Reset wins over iLd in HOLD
        rst = 1'b1; iLd = 1'b1;
        step();
        rst = 1'b0; iLd = 1'b0;
        check("rst_hold_fpd", 64'(fPd), 64'd0);
        check("rst_hold_out_key", 64'(outKey), 64'h0);
        check("rst_hold_rdy", 64'(byteRdy), 64'd0);
        step();
        check("rst_hold_idle_rdy", 64'(byteRdy), 64'd0);
        last_exp = 56'h0;

`ifdef PARITY_CHK_EN
        // Byte 0x12 has even parity and must route the load to ERR
        iLd = 1'b1;
        step();
        iLd = 1'b0;
        rk = 64'h0101011201010101;
        for (int b = 0; b < 8; b++) begin
            byteVld = 1'b1;
            byteIn  = rk[63-8*b -: 8];
            step();
        end
        byteVld = 1'b0;
        check("par_err_flag", 64'(errPar), 64'd1);
        check("par_err_rdy", 64'(byteRdy), 64'd0);
        repeat (3) step();
        check("par_err_sticky", 64'(errPar), 64'd1);
        check("par_err_no_fpd", 64'(fPd), 64'd0);
        iLd = 1'b1;
        step();
        iLd = 1'b0;
        check("par_err_cleared", 64'(errPar), 64'd0);
        check("par_err_reload_rdy", 64'(byteRdy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
